// File: rtl/mc_alu_pkg.sv
// mc_alu shared types: opcode and FSM state enums.
// Also holds the helper that classifies the divider opcodes.
package mc_alu_pkg;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_SLTU = 4'b0101,
    OP_SUB  = 4'b0110,
    OP_SLT  = 4'b0111,
    OP_DIVU = 4'b1010,
    OP_REMU = 4'b1011
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIVIDE,
    S_FINISH
  } state_e;

  function automatic logic is_div(
    input logic [OP_W-1:0] op
  );
    return (op == OP_DIVU) ||
           (op == OP_REMU);
  endfunction

endpackage

// File: rtl/mc_alu_if.sv
// mc_alu request/result bundle.
// master drives start/op/a/b; slave returns result/flags/busy/done.
interface mc_alu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             busy;
  logic             done;

  modport master (
    output start, op, a, b,
    input  result, zero, overflow,
    input  busy, done
  );

  modport slave (
    input  start, op, a, b,
    output result, zero, overflow,
    output busy, done
  );
endinterface

// File: rtl/mc_alu_divider.sv
// Restoring divider, one quotient bit per step.
// Ports: load_i/dividend_i/divisor_i, step_i, last_o, quot_o, rem_o.
module mc_alu_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             last_o,
  output logic [WIDTH-1:0] quot_o,
  output logic [WIDTH-1:0] rem_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST =
    CW'(WIDTH - 1);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] dvs_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;

  // Shift next dividend bit into the
  // partial remainder and try subtracting.
  assign trial = {rem_q, quot_q[WIDTH-1]};
  assign diff  = trial - {1'b0, dvs_q};

  always_comb begin
    rem_d  = diff[WIDTH-1:0];
    quot_d = {quot_q[WIDTH-2:0], 1'b1};
    if (diff[WIDTH]) begin
      rem_d  = trial[WIDTH-1:0];
      quot_d = {quot_q[WIDTH-2:0], 1'b0};
    end
  end

  // Outputs are the post-step values so the
  // caller can capture them on the last step.
  assign quot_o = quot_d;
  assign rem_o  = rem_d;
  assign last_o = step_i && (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quot_q <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
    end else if (load_i) begin
      rem_q  <= '0;
      quot_q <= dividend_i;
      dvs_q  <= divisor_i;
      cnt_q  <= '0;
    end else if (step_i) begin
      rem_q  <= rem_d;
      quot_q <= quot_d;
      cnt_q  <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/mc_alu.sv
// Multi-cycle ALU: 1-cycle logic/arith ops, WIDTH-cycle DIVU/REMU.
// Ports: clk, rst_n, bus (mc_alu_if.slave: start/op/a/b in, result/flags/busy/done out).
module mc_alu
  import mc_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  mc_alu_if.slave  bus
);

  state_e           state_q, state_d;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic             div_go;
  logic             last;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] dif;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;

  // FINISH accepts like IDLE for back-to-back use.
  assign accept = bus.start &&
                  (state_q != S_DIVIDE);
  assign div_go = accept &&
                  is_div(bus.op) &&
                  (bus.b != '0);

  assign sum = bus.a + bus.b;
  assign dif = bus.a - bus.b;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (bus.op)
      OP_AND:  alu_res = bus.a & bus.b;
      OP_OR:   alu_res = bus.a | bus.b;
      OP_ADD: begin
        alu_res = sum;
        alu_ovf =
          (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
          (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = dif;
        alu_ovf =
          (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
          (dif[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SLT:
        alu_res = {{(WIDTH-1){1'b0}},
          $signed(bus.a) < $signed(bus.b)};
      OP_SLTU:
        alu_res = {{(WIDTH-1){1'b0}},
          bus.a < bus.b};
      // Only used when b == 0; nonzero
      // divisors go to the divider.
      OP_DIVU: alu_res = '1;
      OP_REMU: alu_res = bus.a;
      default: alu_res = '0;
    endcase
  end

  mc_alu_divider #(
    .WIDTH (WIDTH)
  ) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (div_go),
    .step_i     (state_q == S_DIVIDE),
    .dividend_i (bus.a),
    .divisor_i  (bus.b),
    .last_o     (last),
    .quot_o     (quot),
    .rem_o      (rem)
  );

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE, S_FINISH: begin
        state_d = S_IDLE;
        if (accept) begin
          state_d = div_go ? S_DIVIDE
                           : S_FINISH;
          if (!div_go) begin
            res_d = alu_res;
            ovf_d = alu_ovf;
          end
        end
      end
      S_DIVIDE: begin
        if (last) begin
          state_d = S_FINISH;
          res_d   = (op_q == OP_REMU) ? rem
                                      : quot;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      res_q   <= '0;
      zero_q  <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      zero_q  <= (res_d == '0);
      ovf_q   <= ovf_d;
      if (accept) op_q <= bus.op;
    end
  end

  assign bus.result   = res_q;
  assign bus.zero     = zero_q;
  assign bus.overflow = ovf_q;
  assign bus.busy     = (state_q == S_DIVIDE);
  assign bus.done     = (state_q == S_FINISH);

endmodule

// File: tb/tb_mc_alu.sv
// Self-checking bench for mc_alu (WIDTH=32).
// Cycle model + literal directed cases + random stimulus.
module tb_mc_alu;

  localparam int W = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  mc_alu_if #(.WIDTH(W)) bus ();

  mc_alu #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(
    input string       name,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  // Reference: what an accepted op must
  // produce and how many cycles until done.
  function automatic void ref_op(
    input  logic [3:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] r,
    output logic         v,
    output int           lat
  );
    longint sa, sb, s;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    r   = '0;
    v   = 1'b0;
    lat = 1;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: begin
        s = sa + sb;
        r = a + b;
        v = (s > 64'sd2147483647) ||
            (s < -64'sd2147483648);
      end
      4'b0110: begin
        s = sa - sb;
        r = a - b;
        v = (s > 64'sd2147483647) ||
            (s < -64'sd2147483648);
      end
      4'b0111: r = (sa < sb) ? 1 : 0;
      4'b0101: r = (a < b) ? 1 : 0;
      4'b1010:
        if (b == 0) r = '1;
        else begin r = a / b; lat = W + 1; end
      4'b1011:
        if (b == 0) r = a;
        else begin r = a % b; lat = W + 1; end
      default: r = '0;
    endcase
  endfunction

  // m_rem: cycles until done (0 = nothing
  // pending); 1 means done this cycle.
  int           m_rem  = 0;
  logic [W-1:0] m_res  = '0;
  logic         m_zero = 1'b1;
  logic         m_ovf  = 1'b0;
  logic [W-1:0] p_res  = '0;
  logic         p_ovf  = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    int  lat;
    logic acc;
    if (!rst_n) begin
      m_rem  = 0;
      m_res  = '0;
      m_zero = 1'b1;
      m_ovf  = 1'b0;
    end else begin
      acc = (m_rem <= 1) && (bus.start === 1'b1);
      if (m_rem > 0) m_rem--;
      if (acc) begin
        ref_op(bus.op, bus.a, bus.b,
               p_res, p_ovf, lat);
        m_rem = lat;
      end
      if (m_rem == 1) begin
        m_res  = p_res;
        m_zero = (p_res == 0);
        m_ovf  = p_ovf;
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", bus.busy, m_rem > 1);
    chk("done", bus.done, m_rem == 1);
    chk("result", bus.result, m_res);
    chk("zero", bus.zero, m_zero);
    chk("overflow", bus.overflow, m_ovf);
  end

  logic [3:0] ops [8] = '{
    4'b0000, 4'b0001, 4'b0010, 4'b0110,
    4'b0111, 4'b0101, 4'b1010, 4'b1011
  };

  function automatic logic [W-1:0] pick_val();
    case ($urandom % 6)
      0: return '0;
      1: return 1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return $urandom % 20;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [3:0] pick_op();
    int k;
    k = $urandom % 10;
    if (k < 8) return ops[k];
    return 4'($urandom);
  endfunction

  // Drive one op, scramble inputs after
  // acceptance, wait for done with a bound.
  task automatic run_lit(
    input string        name,
    input logic [3:0]   op,
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic [W-1:0] er,
    input logic         ev,
    input int           elat
  );
    int n;
    int nb;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op = pick_op();
    bus.a = $urandom;
    bus.b = $urandom;
    n  = 1;
    nb = 0;
    while (!bus.done && n < 200) begin
      if (bus.busy) nb++;
      @(negedge clk);
      n++;
    end
    chk({name, "_lat"}, n, elat);
    chk({name, "_busy"}, nb, elat - 1);
    chk({name, "_res"}, bus.result, er);
    chk({name, "_ovf"}, bus.overflow, ev);
    chk({name, "_zero"}, bus.zero, er == 0);
  endtask

  initial begin
    int n;
    bus.start = 1'b0;
    bus.op    = '0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    chk("rst_result", bus.result, 0);
    chk("rst_zero", bus.zero, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    rst_n = 1'b1;

    run_lit("add_ovf", 4'b0010, 32'h7FFF_FFFF,
            32'h1, 32'h8000_0000, 1'b1, 1);
    run_lit("sub_zero", 4'b0110, 5, 5,
            0, 1'b0, 1);
    run_lit("slt", 4'b0111, 32'hFFFF_FFFF,
            1, 1, 1'b0, 1);
    run_lit("sltu", 4'b0101, 32'hFFFF_FFFF,
            1, 0, 1'b0, 1);
    run_lit("divu", 4'b1010, 100, 7,
            14, 1'b0, 33);
    run_lit("remu", 4'b1011, 100, 7,
            2, 1'b0, 33);
    run_lit("divu0", 4'b1010, 9, 0,
            32'hFFFF_FFFF, 1'b0, 1);
    run_lit("remu0", 4'b1011, 9, 0,
            9, 1'b0, 1);
    run_lit("bad_op", 4'b1111, 3, 4,
            0, 1'b0, 1);

    // start during DIVIDE must be ignored
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = 4'b1010;
    bus.a = 100;
    bus.b = 7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    bus.start = 1'b1;
    bus.op = 4'b0010;
    bus.a = 1;
    bus.b = 1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (!bus.done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ign_done_seen", bus.done, 1);
    chk("ign_res", bus.result, 14);

    // back-to-back start in FINISH
    bus.start = 1'b1;
    bus.op = 4'b0010;
    bus.a = 2;
    bus.b = 3;
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b_done", bus.done, 1);
    chk("b2b_res", bus.result, 5);

    // reset in the middle of a division
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = 4'b1010;
    bus.a = 1000;
    bus.b = 3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_result", bus.result, 0);
    chk("arst_zero", bus.zero, 1);
    chk("arst_busy", bus.busy, 0);
    chk("arst_done", bus.done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.start = 1'b1;
    bus.op = 4'b0010;
    bus.a = 2;
    bus.b = 3;
    @(negedge clk);
    bus.start = 1'b0;
    chk("post_rst_done", bus.done, 1);
    chk("post_rst_res", bus.result, 5);

    // random traffic, incl. starts while busy
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      bus.start = ($urandom % 4 == 0);
      bus.op = pick_op();
      bus.a = pick_val();
      bus.b = pick_val();
    end
    @(negedge clk);
    bus.start = 1'b0;
    repeat (40) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_alu.md
MC_ALU -- requirements
Module: mc_alu

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits (legal range 4..64).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request; sampled only while busy=0.
REQ-005 op  input  4  operation code, captured with start.
REQ-006 a  input  WIDTH  first operand, captured with start.
REQ-007 b  input  WIDTH  second operand, captured with start.
REQ-008 result  output  WIDTH  registered result; holds until the next done.
REQ-009 zero  output  1  registered; 1 when result == 0, updated with result.
REQ-010 overflow  output  1  registered signed overflow flag, updated with result.
REQ-011 busy  output  1  1 while an operation is in progress.
REQ-012 done  output  1  single-cycle pulse; result and flags are valid from this cycle.

Function
REQ-013 Opcodes SHALL be: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 0101 SLTU (unsigned), 1010 DIVU (quotient), 1011 REMU (remainder); all others are invalid.
REQ-014 The FSM SHALL have exactly three states: IDLE, DIVIDE, FINISH.
REQ-015 In IDLE, start=1 SHALL latch op, a and b.
- Single-cycle ops and invalid ops: go to FINISH.
- DIVU/REMU with b != 0: go to DIVIDE.
- DIVU/REMU with b == 0: go to FINISH.
REQ-016 For a single-cycle op accepted at edge T, the result SHALL be written at edge T and done=1 during the cycle after T (latency 1).
REQ-017 DIVU/REMU SHALL use restoring division, one quotient bit per cycle, WIDTH cycles in DIVIDE, with an iteration counter of width $clog2(WIDTH+1).
REQ-018 After the last iteration, DIVU/REMU SHALL write result and go to FINISH; done occurs WIDTH+1 cycles after the accepting edge.
REQ-019 FINISH SHALL last one cycle, assert done=1 with busy=0, and return to IDLE.
REQ-020 A start during FINISH SHALL be accepted exactly as in IDLE, allowing back-to-back operation.
REQ-021 busy SHALL be 1 in DIVIDE only; start while busy=1 SHALL be ignored and leave no side effect.
REQ-022 ADD/SUB SHALL wrap modulo 2^WIDTH; overflow = signed overflow of that operation; overflow=0 for every other op.
REQ-023 SLT/SLTU SHALL produce a WIDTH-bit 1 or 0.
REQ-024 Divide by zero SHALL produce DIVU = all ones and REMU = a, with done at latency 1.
REQ-025 An invalid op SHALL produce result 0, zero=1, overflow=0, done at latency 1.
REQ-026 Changes on a, b or op after acceptance SHALL NOT affect the operation in flight.

Reset
REQ-027 With rst_n=0, outputs SHALL be forced immediately to: result=0, zero=1, overflow=0, busy=0, done=0, state=IDLE, counter=0.
REQ-028 Reset mid-division SHALL abort the operation with no done pulse; the first start SHALL be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-029 Package mc_alu_pkg SHALL hold the op-code localparams/enum and the state enum.
REQ-030 Sub-module mc_alu_divider SHALL hold the restoring divider: remainder/quotient registers, counter, load/step control. It reports quotient and remainder to mc_alu.
REQ-031 Single-cycle ops SHALL be a combinational case in mc_alu feeding the result register.

Verification (WIDTH=32)
REQ-032 ADD a=7FFFFFFF b=1 -> result 80000000, overflow=1, zero=0, done 1 cycle after start.
REQ-033 SUB a=5 b=5 -> result 0, zero=1, overflow=0; SLT a=FFFFFFFF b=1 -> 1; SLTU with the same operands -> 0.
REQ-034 DIVU a=100 b=7 -> result 14, done 33 cycles after start, busy high for 32 cycles; REMU same operands -> 2.
REQ-035 DIVU a=9 b=0 -> FFFFFFFF at latency 1; REMU a=9 b=0 -> 9.
REQ-036 start pulsed during DIVIDE with op=ADD -> ignored, division result unaffected; back-to-back start during FINISH -> accepted.
REQ-037 rst_n low at iteration 10 of a division -> outputs at reset values immediately, no done; a new ADD 2+3 after release -> 5.
